// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch: button-FSM state codes, the internal
// timekeeping FSM encoding, and BCD digit limits.
package stopwatch_pkg;

    // Mode codes produced by the upstream button FSM
    localparam logic [2:0] ST_RESET = 3'b001;
    localparam logic [2:0] ST_COUNT = 3'b010;
    localparam logic [2:0] ST_PAUSE = 3'b011;
    localparam logic [2:0] ST_STOP  = 3'b100;

    // Timekeeping FSM
    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_RUN  = 2'd1,
        FSM_HOLD = 2'd2,
        FSM_DONE = 2'd3
    } fsm_t;

    localparam int unsigned DIGIT_W = 4;

    // Highest legal value per BCD digit position
    localparam logic [DIGIT_W-1:0] BCD_MAX_9 = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MAX_5 = 4'd5;

endpackage

// File: rtl/stopwatch_core_if.sv
// Mode input and MM:SS.CC display/status outputs of the stopwatch core.
//   state      : 3-bit mode code from the button FSM
//   cs_*/sec_*/min_* : six BCD digits
//   running/done     : FSM status
//   tick_100hz/overflow : single-cycle event pulses
// master: controller/display side; slave: stopwatch_core.
interface stopwatch_core_if;
    import stopwatch_pkg::*;

    logic [2:0]         state;
    logic [DIGIT_W-1:0] cs_ones;
    logic [DIGIT_W-1:0] cs_tens;
    logic [DIGIT_W-1:0] sec_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] min_tens;
    logic               running;
    logic               done;
    logic               tick_100hz;
    logic               overflow;

    modport master (
        output state,
        input  cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
        input  running, done, tick_100hz, overflow
    );

    modport slave (
        input  state,
        output cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
        output running, done, tick_100hz, overflow
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Single BCD digit counting 0..MAX; rolls over to 0 and raises carry.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (priority over en)
//   en         : advance by one on this edge
//   digit      : registered digit value
//   carry      : combinational, en && digit==MAX (enables the next stage)
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = BCD_MAX_9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (en) begin
            digit <= (digit == MAX) ? '0 : digit + DIGIT_W'(1);
        end
    end

    assign carry = en && (digit == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: 100 Hz prescaler, IDLE/RUN/HOLD/DONE FSM and a
// six-digit BCD cascade holding MM:SS.CC.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of stopwatch_core_if (mode in, digits/status out)
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_DIV = CLK_HZ / 100,
    parameter bit          SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    stopwatch_core_if.slave   bus
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam int unsigned NDIG = 6;

    fsm_t               r_fsm, w_fsm_nxt;
    logic [PW-1:0]      r_presc, w_presc_nxt;
    logic               r_running, r_done, r_tick, r_ovf;
    logic               w_clr, w_inc, w_all_max;
    logic [DIGIT_W-1:0] w_d [NDIG];
    logic [NDIG-1:0]    w_c;

    // Display already at 59:59.99
    assign w_all_max = (w_d[0] == BCD_MAX_9) && (w_d[1] == BCD_MAX_9) &&
                       (w_d[2] == BCD_MAX_9) && (w_d[3] == BCD_MAX_5) &&
                       (w_d[4] == BCD_MAX_9) && (w_d[5] == BCD_MAX_5);

    // Next state, prescaler and increment decision
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_presc_nxt = r_presc;
        w_clr       = 1'b0;
        w_inc       = 1'b0;

        case (bus.state)
            ST_RESET: begin
                w_fsm_nxt   = FSM_IDLE;
                w_presc_nxt = '0;
                w_clr       = 1'b1;
            end
            ST_COUNT: if (r_fsm != FSM_DONE) w_fsm_nxt = FSM_RUN;
            ST_PAUSE: if (r_fsm == FSM_RUN) w_fsm_nxt = FSM_HOLD;
            ST_STOP: begin
                w_fsm_nxt   = FSM_DONE;
                w_presc_nxt = '0;
            end
            default: ;
        endcase

        // Only edges that start and stay in RUN advance time; a mode change wins
        if (r_fsm == FSM_RUN && w_fsm_nxt == FSM_RUN) begin
            if (r_presc == PRESC_LAST) begin
                w_presc_nxt = '0;
                if (SATURATE && w_all_max) begin
                    w_fsm_nxt = FSM_DONE;
                end else begin
                    w_inc = 1'b1;
                end
            end else begin
                w_presc_nxt = r_presc + PW'(1);
            end
        end
    end

    // FSM, prescaler and status/pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm     <= FSM_IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_tick    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_fsm     <= w_fsm_nxt;
            r_presc   <= w_presc_nxt;
            r_running <= (w_fsm_nxt == FSM_RUN);
            r_done    <= (w_fsm_nxt == FSM_DONE);
            r_tick    <= w_inc;
            r_ovf     <= w_c[NDIG-1];
        end
    end

    // Digit cascade cs_ones -> min_tens; carries resolve within one edge
    bcd_mod_counter #(.MAX(BCD_MAX_9)) u_cs_ones (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .en(w_inc),
        .digit(w_d[0]), .carry(w_c[0]));
    bcd_mod_counter #(.MAX(BCD_MAX_9)) u_cs_tens (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .en(w_c[0]),
        .digit(w_d[1]), .carry(w_c[1]));
    bcd_mod_counter #(.MAX(BCD_MAX_9)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .en(w_c[1]),
        .digit(w_d[2]), .carry(w_c[2]));
    bcd_mod_counter #(.MAX(BCD_MAX_5)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .en(w_c[2]),
        .digit(w_d[3]), .carry(w_c[3]));
    bcd_mod_counter #(.MAX(BCD_MAX_9)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .en(w_c[3]),
        .digit(w_d[4]), .carry(w_c[4]));
    bcd_mod_counter #(.MAX(BCD_MAX_5)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .en(w_c[4]),
        .digit(w_d[5]), .carry(w_c[5]));

    assign bus.cs_ones    = w_d[0];
    assign bus.cs_tens    = w_d[1];
    assign bus.sec_ones   = w_d[2];
    assign bus.sec_tens   = w_d[3];
    assign bus.min_ones   = w_d[4];
    assign bus.min_tens   = w_d[5];
    assign bus.running    = r_running;
    assign bus.done       = r_done;
    assign bus.tick_100hz = r_tick;
    assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: wrap (dut0) and saturate (dut1) variants.
module tb_stopwatch_core;
    import stopwatch_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   ticks;

    stopwatch_core_if bus0();
    stopwatch_core_if bus1();

    stopwatch_core #(.CLK_HZ(400), .TICK_DIV(4), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    stopwatch_core #(.CLK_HZ(400), .TICK_DIV(4), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    function automatic logic [23:0] t0();
        return {bus0.min_tens, bus0.min_ones, bus0.sec_tens,
                bus0.sec_ones, bus0.cs_tens, bus0.cs_ones};
    endfunction

    function automatic logic [23:0] t1();
        return {bus1.min_tens, bus1.min_ones, bus1.sec_tens,
                bus1.sec_ones, bus1.cs_tens, bus1.cs_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_state(input logic [2:0] code);
        bus0.state = code;
        bus1.state = code;
    endtask

    initial begin
        set_state(ST_RESET);

        // Reset state
        step(2);
        check("rst_time0", 32'(t0()), 32'h0);
        check("rst_run0", 32'(bus0.running), 32'h0);
        check("rst_done0", 32'(bus0.done), 32'h0);
        check("rst_tick0", 32'(bus0.tick_100hz), 32'h0);
        check("rst_ovf0", 32'(bus0.overflow), 32'h0);
        check("rst_time1", 32'(t1()), 32'h0);
        rst_n = 1'b1;
        step(1);
        check("idle_time", 32'(t0()), 32'h0);

        // 1) entry edge plus 40 counting edges -> 10 ticks
        set_state(ST_COUNT);
        ticks = 0;
        repeat (41) begin
            step(1);
            if (bus0.tick_100hz) ticks++;
        end
        check("t1_ticks", 32'(ticks), 32'd10);
        check("t1_time", 32'(t0()), 32'h000010);
        check("t1_run", 32'(bus0.running), 32'h1);

        // 2) count on to 00:59.99, then one clean carry into minutes
        step(4 * 5989);
        check("t2_preload", 32'(t0()), 32'h005999);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t2_steady", 32'(t0()), 32'h005999);
        end
        step(1);
        check("t2_carry", 32'(t0()), 32'h010000);
        check("t2_tick", 32'(bus0.tick_100hz), 32'h1);

        // 3) pause with prescaler at 2, hold 100 clk, resume keeps the phase
        step(2);
        set_state(ST_PAUSE);
        step(1);
        check("t3_hold_run", 32'(bus0.running), 32'h0);
        ticks = 0;
        repeat (100) begin
            step(1);
            if (bus0.tick_100hz) ticks++;
        end
        check("t3_hold_ticks", 32'(ticks), 32'd0);
        check("t3_hold_time", 32'(t0()), 32'h010000);
        set_state(ST_COUNT);
        step(1);
        check("t3_resume_run", 32'(bus0.running), 32'h1);
        step(1);
        check("t3_r1_tick", 32'(bus0.tick_100hz), 32'h0);
        check("t3_r1_time", 32'(t0()), 32'h010000);
        step(1);
        check("t3_r2_tick", 32'(bus0.tick_100hz), 32'h1);
        check("t3_r2_time", 32'(t0()), 32'h010001);

        // 4) stop freezes; count/pause ignored; reset clears
        set_state(ST_STOP);
        step(1);
        check("t4_done", 32'(bus0.done), 32'h1);
        check("t4_run", 32'(bus0.running), 32'h0);
        check("t4_time", 32'(t0()), 32'h010001);
        set_state(ST_COUNT);
        step(10);
        check("t4_cnt_done", 32'(bus0.done), 32'h1);
        check("t4_cnt_time", 32'(t0()), 32'h010001);
        set_state(ST_PAUSE);
        step(10);
        check("t4_pause_done", 32'(bus0.done), 32'h1);
        check("t4_pause_time", 32'(t0()), 32'h010001);
        set_state(ST_RESET);
        step(1);
        check("t4_clr_time", 32'(t0()), 32'h0);
        check("t4_clr_done", 32'(bus0.done), 32'h0);
        check("t4_clr_run", 32'(bus0.running), 32'h0);

        // 6a) async reset between edges clears at once
        set_state(ST_COUNT);
        step(10);
        check("t6_pre_time", 32'(t0()), 32'h000002);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_time", 32'(t0()), 32'h0);
        check("t6_async_run", 32'(bus0.running), 32'h0);
        check("t6_async_tick", 32'(bus0.tick_100hz), 32'h0);
        set_state(ST_RESET);
        #3;
        rst_n = 1'b1;
        step(3);
        check("t6_post_time", 32'(t0()), 32'h0);
        check("t6_post_run", 32'(bus0.running), 32'h0);

        // 6b) illegal code 111 in RUN keeps counting
        set_state(ST_COUNT);
        step(5);
        check("t6_cnt_time", 32'(t0()), 32'h000001);
        set_state(3'b111);
        step(4);
        check("t6_ill_time", 32'(t0()), 32'h000002);
        check("t6_ill_run", 32'(bus0.running), 32'h1);

        // 5) preload 59:59.99 while idle, then one tick: wrap vs saturate
        set_state(ST_RESET);
        step(1);
        set_state(3'b000);
        force dut0.u_cs_ones.digit  = 4'd9;
        force dut0.u_cs_tens.digit  = 4'd9;
        force dut0.u_sec_ones.digit = 4'd9;
        force dut0.u_sec_tens.digit = 4'd5;
        force dut0.u_min_ones.digit = 4'd9;
        force dut0.u_min_tens.digit = 4'd5;
        force dut1.u_cs_ones.digit  = 4'd9;
        force dut1.u_cs_tens.digit  = 4'd9;
        force dut1.u_sec_ones.digit = 4'd9;
        force dut1.u_sec_tens.digit = 4'd5;
        force dut1.u_min_ones.digit = 4'd9;
        force dut1.u_min_tens.digit = 4'd5;
        #1;
        release dut0.u_cs_ones.digit;
        release dut0.u_cs_tens.digit;
        release dut0.u_sec_ones.digit;
        release dut0.u_sec_tens.digit;
        release dut0.u_min_ones.digit;
        release dut0.u_min_tens.digit;
        release dut1.u_cs_ones.digit;
        release dut1.u_cs_tens.digit;
        release dut1.u_sec_ones.digit;
        release dut1.u_sec_tens.digit;
        release dut1.u_min_ones.digit;
        release dut1.u_min_tens.digit;
        step(1);
        check("t5_load0", 32'(t0()), 32'h595999);
        check("t5_load1", 32'(t1()), 32'h595999);
        set_state(ST_COUNT);
        step(4);
        check("t5_pre0", 32'(t0()), 32'h595999);
        check("t5_pre1", 32'(t1()), 32'h595999);
        step(1);
        check("t5_wrap_time0", 32'(t0()), 32'h000000);
        check("t5_wrap_ovf0", 32'(bus0.overflow), 32'h1);
        check("t5_wrap_tick0", 32'(bus0.tick_100hz), 32'h1);
        check("t5_wrap_run0", 32'(bus0.running), 32'h1);
        check("t5_sat_time1", 32'(t1()), 32'h595999);
        check("t5_sat_done1", 32'(bus1.done), 32'h1);
        check("t5_sat_ovf1", 32'(bus1.overflow), 32'h0);
        check("t5_sat_run1", 32'(bus1.running), 32'h0);
        step(1);
        check("t5_ovf_end0", 32'(bus0.overflow), 32'h0);
        check("t5_tick_end0", 32'(bus0.tick_100hz), 32'h0);
        check("t5_after_time0", 32'(t0()), 32'h000000);
        check("t5_after_time1", 32'(t1()), 32'h595999);
        check("t5_after_done1", 32'(bus1.done), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
